ram16_port_arbiter: RTL and testbench

Round-robin arbiter sharing one port of the 1024x32 dual-port RAM among several single-clock requesters. Accepts one read or write per cycle via a req/gnt handshake and registers the winning command onto the RAM port. Steers returned read data back to the issuing requester with a per-requester valid strobe. Sits between client engines and port A (or port B) of `RAM16_s36_s36_altera`; the RAM port clock is tied to `clock`.

---
 rtl/ram16_port_arbiter_pkg.sv | 24 ++
 rtl/ram16_port_arbiter_if.sv | 28 ++
 rtl/ram16_port_arbiter_rr_arbiter.sv | 39 +++
 rtl/ram16_port_arbiter.sv | 109 ++++++++++
 tb/tb_ram16_port_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ram16_port_arbiter_pkg.sv
// Shared widths and the read-tracking tag type for the RAM16 port arbiter.
package ram16_arb_pkg;

  localparam int RAM16_ADDR_W     = 10;
  localparam int RAM16_DATA_W     = 32;
  localparam int RAM16_RD_LATENCY = 2;
  localparam int RAM16_NUM_REQ    = 4;
  localparam int RAM16_MAX_REQ    = 8;
  // Sized for the largest supported requester count so one tag type serves all builds.
  localparam int RAM16_ID_W       = $clog2(RAM16_MAX_REQ);

  typedef struct packed {
    logic                  valid;
    logic [RAM16_ID_W-1:0] id;
  } rd_tag_t;

  function automatic rd_tag_t make_tag(input logic valid, input logic [RAM16_ID_W-1:0] id);
    rd_tag_t t;
    t.valid = valid;
    t.id    = id;
    return t;
  endfunction

endpackage

// File: rtl/ram16_port_arbiter_if.sv
// Client request/response bus plus the shared RAM port, bundled for the arbiter.
interface ram16_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic [ADDR_W-1:0]         ram_address;
  logic [DATA_W-1:0]         ram_data;
  logic                      ram_wren;
  logic [DATA_W-1:0]         ram_q;

  modport master (
    output req, we, addr, wdata, ram_q,
    input  gnt, rvalid, rdata, ram_address, ram_data, ram_wren
  );

  modport slave (
    input  req, we, addr, wdata, ram_q,
    output gnt, rvalid, rdata, ram_address, ram_data, ram_wren
  );
endinterface

// File: rtl/ram16_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_gnt wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_gnt,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    win_idx
);

  logic found_s;

  // Two passes: indices above the pointer first, then wrap to 0..last_gnt.
  always_comb begin
    gnt     = '0;
    win_idx = '0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_s && req[i] && (i > int'(last_gnt))) begin
        found_s = 1'b1;
        gnt[i]  = 1'b1;
        win_idx = ID_W'(i);
      end else begin
        found_s = found_s;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_s && req[i] && (i <= int'(last_gnt))) begin
        found_s = 1'b1;
        gnt[i]  = 1'b1;
        win_idx = ID_W'(i);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/ram16_port_arbiter.sv
// Round-robin sharing of one RAM16 port; registers the winning command and
// steers read data back to its issuer after the RAM read latency.
module ram16_port_arbiter
  import ram16_arb_pkg::*;
#(
  parameter int NUM_REQ    = RAM16_NUM_REQ,
  parameter int ADDR_W     = RAM16_ADDR_W,
  parameter int DATA_W     = RAM16_DATA_W,
  parameter int RD_LATENCY = RAM16_RD_LATENCY
) (
  input logic        clock,
  input logic        reset_n,
  ram16_arb_if.slave bus
);

  logic [NUM_REQ-1:0]    gnt_s;
  logic [RAM16_ID_W-1:0] win_s;
  logic                  xfer_s;
  logic                  sel_we_s;
  logic [ADDR_W-1:0]     sel_addr_s;
  logic [DATA_W-1:0]     sel_data_s;
  rd_tag_t               tag_in_s;
  rd_tag_t               tag_out_s;
  logic [NUM_REQ-1:0]    rvalid_s;

  logic [RAM16_ID_W-1:0] last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0]     ram_address_q, ram_address_d;
  logic [DATA_W-1:0]     ram_data_q, ram_data_d;
  logic                  ram_wren_q, ram_wren_d;
  rd_tag_t               tag_q [RD_LATENCY+1];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (RAM16_ID_W)
  ) u_rr_arbiter (
    .req      (bus.req),
    .last_gnt (last_gnt_q),
    .gnt      (gnt_s),
    .win_idx  (win_s)
  );

  // Winner command mux (one-hot select) and next-state for pointer, command and tag.
  always_comb begin
    sel_we_s   = 1'b0;
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_s[i]) begin
        sel_we_s   = bus.we[i];
        sel_addr_s = bus.addr[i*ADDR_W +: ADDR_W];
        sel_data_s = bus.wdata[i*DATA_W +: DATA_W];
      end else begin
        sel_we_s   = sel_we_s;
      end
    end
    xfer_s = |(bus.req & gnt_s);
    if (xfer_s) begin
      last_gnt_d    = win_s;
      ram_address_d = sel_addr_s;
      ram_data_d    = sel_data_s;
      ram_wren_d    = sel_we_s;
    end else begin
      last_gnt_d    = last_gnt_q;
      ram_address_d = ram_address_q;
      ram_data_d    = ram_data_q;
      ram_wren_d    = 1'b0;
    end
    tag_in_s = make_tag(xfer_s && !sel_we_s, win_s);
  end

  // Pointer, RAM command register and read-tag pipeline.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt_q    <= RAM16_ID_W'(NUM_REQ-1);
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      for (int i = 0; i <= RD_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      last_gnt_q    <= last_gnt_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      tag_q[0]      <= tag_in_s;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Decode the tag leaving the pipe into a one-hot read-valid strobe.
  always_comb begin
    tag_out_s = tag_q[RD_LATENCY];
    rvalid_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rvalid_s[i] = tag_out_s.valid && (tag_out_s.id == RAM16_ID_W'(i));
    end
  end

  assign bus.gnt         = reset_n ? gnt_s : '0;
  assign bus.rvalid      = rvalid_s;
  assign bus.rdata       = bus.ram_q;
  assign bus.ram_address = ram_address_q;
  assign bus.ram_data    = ram_data_q;
  assign bus.ram_wren    = ram_wren_q;

endmodule

// File: tb/tb_ram16_port_arbiter.sv
// Directed bench for ram16_port_arbiter with a behavioural RAM16 port model.
module tb_ram16_port_arbiter;

  localparam int NR = 4;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clock;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  ram16_arb_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  ram16_port_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .RD_LATENCY (2)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model: registered address, registered q (two cycles), write at the command edge.
  logic [DW-1:0] mem [1024];
  logic [AW-1:0] ra_q;
  logic [DW-1:0] q_q;
  assign bus.ram_q = q_q;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[5] = 32'hDEAD_BEEF;
    ra_q   = '0;
    q_q    = '0;
    forever begin
      @(posedge clock);
      q_q  <= mem[ra_q];
      ra_q <= bus.ram_address;
      if (bus.ram_wren) mem[bus.ram_address] = bus.ram_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cmd(input int r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we[r]            = w;
    bus.addr[r*AW +: AW] = a;
    bus.wdata[r*DW +: DW] = d;
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.req   = 4'b1111;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;

    // Reset state, gnt forced low even with requests pending
    repeat (2) @(posedge clock);
    #1;
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_rvalid", 32'(bus.rvalid), 32'h0);
    check("rst_wren", 32'(bus.ram_wren), 32'h0);
    check("rst_addr", 32'(bus.ram_address), 32'h0);
    check("rst_data", bus.ram_data, 32'h0);
    reset_n = 1'b1;
    bus.req = 4'b0000;

    // Single read: requester 2 reads 0x005
    set_cmd(2, 1'b0, 10'h005, 32'h0);
    bus.req = 4'b0100;
    #1;
    check("rd_gnt", 32'(bus.gnt), 32'h4);
    tick();
    bus.req = 4'b0000;
    check("rd_cmd_addr", 32'(bus.ram_address), 32'h005);
    check("rd_cmd_wren", 32'(bus.ram_wren), 32'h0);
    tick();
    check("rd_t2_rvalid", 32'(bus.rvalid), 32'h0);
    tick();
    check("rd_t3_rvalid", 32'(bus.rvalid), 32'h4);
    check("rd_t3_rdata", bus.rdata, 32'hDEAD_BEEF);
    tick();
    check("rd_t4_rvalid", 32'(bus.rvalid), 32'h0);

    // Write 0x3FF from requester 1, then read it back from requester 3
    set_cmd(1, 1'b1, 10'h3FF, 32'h1234_5678);
    bus.req = 4'b0010;
    #1;
    check("wr_gnt", 32'(bus.gnt), 32'h2);
    tick();
    check("wr_cmd_wren", 32'(bus.ram_wren), 32'h1);
    check("wr_cmd_addr", 32'(bus.ram_address), 32'h3FF);
    check("wr_cmd_data", bus.ram_data, 32'h1234_5678);
    set_cmd(3, 1'b0, 10'h3FF, 32'h0);
    bus.req = 4'b1000;
    #1;
    check("raw_gnt", 32'(bus.gnt), 32'h8);
    tick();
    bus.req = 4'b0000;
    check("raw_cmd_wren", 32'(bus.ram_wren), 32'h0);
    check("raw_rvalid_a", 32'(bus.rvalid), 32'h0);
    tick();
    check("raw_rvalid_wr", 32'(bus.rvalid), 32'h0);
    tick();
    check("raw_rvalid", 32'(bus.rvalid), 32'h8);
    check("raw_rdata", bus.rdata, 32'h1234_5678);

    // Fairness: last grant 1, then 0 and 3 together -> 3 first
    set_cmd(1, 1'b0, 10'h005, 32'h0);
    bus.req = 4'b0010;
    #1;
    check("fair_g1", 32'(bus.gnt), 32'h2);
    tick();
    set_cmd(0, 1'b0, 10'h005, 32'h0);
    bus.req = 4'b1001;
    #1;
    check("fair_g3", 32'(bus.gnt), 32'h8);
    tick();
    bus.req = 4'b0001;
    #1;
    check("fair_g0", 32'(bus.gnt), 32'h1);
    tick();
    bus.req = 4'b0000;
    check("fair_rv1", 32'(bus.rvalid), 32'h2);
    check("fair_rd1", bus.rdata, 32'hDEAD_BEEF);
    tick();
    check("fair_rv3", 32'(bus.rvalid), 32'h8);
    check("fair_rd3", bus.rdata, 32'h1234_5678);
    tick();
    check("fair_rv0", 32'(bus.rvalid), 32'h1);
    check("fair_rd0", bus.rdata, 32'hDEAD_BEEF);

    // Fresh reset, then all four read continuously: grants 0,1,2,3,... with no gaps
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int r = 0; r < NR; r++) set_cmd(r, 1'b0, 10'(10'h010 + r), 32'h0);
    for (int k = 0; k < 11; k++) begin
      bus.req = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      check("rr_gnt", 32'(bus.gnt), (k < 8) ? (32'h1 << (k % 4)) : 32'h0);
      if (k >= 3) begin
        check("rr_rvalid", 32'(bus.rvalid), 32'h1 << ((k - 3) % 4));
        check("rr_rdata", bus.rdata, 32'hC0DE_0010 + 32'((k - 3) % 4));
      end else begin
        check("rr_rvalid_pre", 32'(bus.rvalid), 32'h0);
      end
      tick();
    end

    // Reset mid-stream: two reads in flight are dropped
    bus.req = 4'b0001;
    #1;
    check("mid_gnt0", 32'(bus.gnt), 32'h1);
    tick();
    bus.req = 4'b0010;
    #1;
    check("mid_gnt1", 32'(bus.gnt), 32'h2);
    tick();
    bus.req = 4'b0000;
    reset_n = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(bus.rvalid), 32'h0);
    check("mid_rst_wren", 32'(bus.ram_wren), 32'h0);
    check("mid_rst_addr", 32'(bus.ram_address), 32'h0);
    check("mid_rst_data", bus.ram_data, 32'h0);
    check("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("mid_no_rvalid", 32'(bus.rvalid), 32'h0);
      tick();
    end
    set_cmd(0, 1'b0, 10'h020, 32'h0);
    bus.req = 4'b1111;
    #1;
    check("post_rst_gnt", 32'(bus.gnt), 32'h1);
    tick();
    bus.req = 4'b0000;
    check("post_rst_addr", 32'(bus.ram_address), 32'h020);
    tick();
    tick();
    check("post_rst_rvalid", 32'(bus.rvalid), 32'h1);
    check("post_rst_rdata", bus.rdata, 32'hC0DE_0020);
    tick();

    // Idle for 10 cycles
    for (int k = 0; k < 10; k++) begin
      check("idle_gnt", 32'(bus.gnt), 32'h0);
      check("idle_wren", 32'(bus.ram_wren), 32'h0);
      check("idle_addr", 32'(bus.ram_address), 32'h020);
      check("idle_rvalid", 32'(bus.rvalid), 32'h0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
